fft_sample_collector: RTL and testbench
=======================================

# fft_sample_collector

Serial-to-parallel input stage of the FFT datapath: accepts one sample per cycle over a valid/ready stream, steers each sample into one slot of an N-point frame register through a one-hot write decode, and presents the completed frame in parallel to the FFT core. It sits directly upstream of the FFT demux/decoder stage and produces the wide parallel frame that stage and the butterfly array consume.

## Interface
- `DATA_WIDTH`, 8, bits per sample.
- `N_POINTS`, 16, frame length; power of two, 2..2048.
- `IDX_W`, $clog2(N_POINTS), derived, width of the write index; not to be overridden.

- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `s_valid`  in  1  input sample valid.
- `s_ready`  out  1  collector can accept a sample.
- `s_data`  in  DATA_WIDTH  input sample.
- `frame_abort`  in  1  synchronous discard of the partial frame.
- `frame_valid`  out  1  complete frame presented on `frame_data`.
- `frame_ready`  in  1  FFT core consumes the frame.
- `frame_data`  out  N_POINTS*DATA_WIDTH  slot i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `wr_idx`  out  IDX_W  count of samples accepted in the current frame.

## Operation
- Two-state FSM: FILL, HOLD. Reset state FILL.
- FILL: `s_ready`=1, `frame_valid`=0. Accept on `s_valid && s_ready`: slot `slot(wr_idx)` <= `s_data` (one-hot decode of slot address gates the write enable of each slot register), `wr_idx` <= `wr_idx`+1.
- Accepting when `wr_idx`==N_POINTS-1: write last slot, `wr_idx` wraps to 0, FSM -> HOLD.
- HOLD: `s_ready`=0, `frame_valid`=1, `frame_data` stable. On `frame_ready`=1: FSM -> FILL. No slot is cleared between frames; every slot is overwritten by the next frame.
- `frame_abort`=1 in FILL: `wr_idx` <= 0, no write that cycle even if `s_valid`=1 (abort wins; `s_ready` remains 1 but the beat is dropped). Slots keep stale values. In HOLD, `frame_abort` is ignored.
- `slot(k)` = k by default; see Configuration.
- Only one write per cycle; exactly one slot enable active per accepted beat, none otherwise.

## Timing
- Reset values: FSM=FILL, `s_ready`=1, `frame_valid`=0, `wr_idx`=0, all slots (`frame_data`)=0.
- `s_ready` and `frame_valid` are decoded from registered state only; no combinational path from `s_valid` or `frame_ready` to any output.
- Latency: `frame_valid` rises the cycle after the edge that accepts sample N_POINTS-1; written sample visible on `frame_data` the cycle after acceptance.
- Throughput: N_POINTS beats back-to-back, then at least one HOLD cycle; with `frame_ready` held 1, one frame per N_POINTS+1 cycles.
- Handshake in HOLD completes on the edge where `frame_ready`=1; `s_ready` returns to 1 the following cycle.
- `rst` asserted mid-frame or in HOLD: immediate return to reset values; partial or pending frame lost.

## Configuration
- `FFT_BITREV_EN`: defined -> `slot(k)` = bit-reversal of k over IDX_W bits, so `frame_data` is in decimation-in-time input order. Undefined -> `slot(k)` = k (natural order). Handshake, timing and `wr_idx` behaviour identical in both builds.

## Test plan
- Reset: assert `rst` mid-frame (after 5 beats) -> `s_ready`=1, `frame_valid`=0, `wr_idx`=0, `frame_data`=0 without a clock edge.
- Natural order (N=16, DW=8, macro undefined): feed 0x10..0x1F back-to-back -> `frame_valid`=1 one cycle after 16th beat, slot i = 0x10+i, `s_ready`=0 while held.
- Bit-reversed (`FFT_BITREV_EN`): same stimulus -> slot 1 = 0x18, slot 8 = 0x11, slot 3 = 0x1C, slot 15 = 0x1F.
- Backpressure: hold `frame_ready`=0 for 10 cycles with `s_valid`=1 -> no beats accepted, `frame_data` unchanged; `frame_ready`=1 -> `s_ready`=1 next cycle, next frame fills normally.
- Abort: 7 beats, then `frame_abort`=1 with `s_valid`=1 and `s_data`=0xAA -> `wr_idx`=0, 0xAA not written; next 16 beats form a correct frame.
- Gaps: 16 beats with `s_valid` toggling randomly -> `frame_valid` exactly after 16th accepted beat, contents match accepted order.

Source files
------------

// File: rtl/fft_sample_collector.sv
// Serial-to-parallel frame collector for the FFT input stage: valid/ready beats are
// steered into N_POINTS slot registers. Define FFT_BITREV_EN for bit-reversed slot order.

module fft_sample_slot #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [DATA_WIDTH-1:0] d_i,
    output logic [DATA_WIDTH-1:0] q_o
);
    logic [DATA_WIDTH-1:0] slot_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       slot_q <= '0;
        else if (we_i) slot_q <= d_i;
    end

    assign q_o = slot_q;
endmodule

module fft_sample_collector #(
    parameter int DATA_WIDTH = 8,
    parameter int N_POINTS   = 16,
    parameter int IDX_W      = $clog2(N_POINTS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [DATA_WIDTH-1:0]          s_data,
    input  logic                           frame_abort,
    output logic                           frame_valid,
    input  logic                           frame_ready,
    output logic [N_POINTS*DATA_WIDTH-1:0] frame_data,
    output logic [IDX_W-1:0]               wr_idx
);
    typedef enum logic {FILL, HOLD} state_e;

    state_e                state_q;
    logic                  s_ready_q;
    logic                  frame_valid_q;
    logic [IDX_W-1:0]      wr_idx_q;
    logic [IDX_W-1:0]      wr_idx_d;
    logic [IDX_W-1:0]      slot_addr;
    logic                  accept;
    logic [N_POINTS-1:0]   slot_we;

    function automatic logic [IDX_W-1:0] slot_of(input logic [IDX_W-1:0] k);
        logic [IDX_W-1:0] r;
`ifdef FFT_BITREV_EN
        for (int b = 0; b < IDX_W; b++) r[b] = k[IDX_W-1-b];
`else
        r = k;
`endif
        return r;
    endfunction

    // Abort takes priority over a concurrent beat; s_ready stays high but the beat is dropped.
    assign accept    = s_valid && s_ready_q && !frame_abort;
    assign slot_addr = slot_of(wr_idx_q);
    assign wr_idx_d  = wr_idx_q + IDX_W'(1);

    always_comb begin
        slot_we = '0;
        for (int i = 0; i < N_POINTS; i++)
            slot_we[i] = accept && (slot_addr == IDX_W'(i));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FILL;
            s_ready_q     <= 1'b1;
            frame_valid_q <= 1'b0;
            wr_idx_q      <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (frame_abort) begin
                        wr_idx_q <= '0;
                    end else if (s_valid) begin
                        if (wr_idx_q == IDX_W'(N_POINTS-1)) begin
                            wr_idx_q      <= '0;
                            state_q       <= HOLD;
                            s_ready_q     <= 1'b0;
                            frame_valid_q <= 1'b1;
                        end else begin
                            wr_idx_q <= wr_idx_d;
                        end
                    end
                end
                HOLD: begin
                    if (frame_ready) begin
                        state_q       <= FILL;
                        s_ready_q     <= 1'b1;
                        frame_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= FILL;
                    s_ready_q     <= 1'b1;
                    frame_valid_q <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < N_POINTS; i++) begin : g_slot
        fft_sample_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
            .clk  (clk),
            .rst  (rst),
            .we_i (slot_we[i]),
            .d_i  (s_data),
            .q_o  (frame_data[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign s_ready     = s_ready_q;
    assign frame_valid = frame_valid_q;
    assign wr_idx      = wr_idx_q;
endmodule

// File: tb/tb_fft_sample_collector.sv
// Bench for fft_sample_collector: constant vector table, directed corner sequences and
// random traffic checked against an array-based frame model.

module tb_fft_sample_collector;
    localparam int DW = 8;
    localparam int N  = 16;
    localparam int FW = N * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid, s_ready, frame_abort, frame_valid, frame_ready;
    logic [DW-1:0] s_data;
    logic [FW-1:0] frame_data;
    logic [3:0]    wr_idx;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mem_m [N];
    int            cnt_m;
    bit            hold_m;

    always #5 clk = ~clk;

    fft_sample_collector #(.DATA_WIDTH(DW), .N_POINTS(N)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .frame_abort(frame_abort), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .frame_data(frame_data), .wr_idx(wr_idx)
    );

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          ab;
        logic          fr;
        logic          e_rdy;
        logic          e_fv;
        logic [3:0]    e_idx;
        logic [DW-1:0] e_slot0;
    } vec_t;

    vec_t vecs [6];

    function automatic int slot_m(input int k);
        int r = 0;
`ifdef FFT_BITREV_EN
        for (int b = 0; b < 4; b++) r |= ((k >> b) & 1) << (3 - b);
`else
        r = k;
`endif
        return r;
    endfunction

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) mem_m[i] = '0;
        cnt_m  = 0;
        hold_m = 0;
    endtask

    task automatic check_model();
        logic [FW-1:0] fd;
        for (int i = 0; i < N; i++) fd[i*DW +: DW] = mem_m[i];
        chk("s_ready", FW'(s_ready), FW'(!hold_m));
        chk("frame_valid", FW'(frame_valid), FW'(hold_m));
        chk("wr_idx", FW'(wr_idx), FW'(cnt_m));
        chk("frame_data", frame_data, fd);
    endtask

    // Apply one cycle of inputs, advance the model by the same rules, then compare.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic ab, input logic fr);
        s_valid = v; s_data = d; frame_abort = ab; frame_ready = fr;
        if (!hold_m) begin
            if (ab) cnt_m = 0;
            else if (v) begin
                mem_m[slot_m(cnt_m)] = d;
                cnt_m++;
                if (cnt_m == N) begin cnt_m = 0; hold_m = 1; end
            end
        end else if (fr) hold_m = 0;
        @(posedge clk); #1;
        check_model();
    endtask

    logic [FW-1:0] saved;

    initial begin
        vecs[0] = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 8'hA1};
        vecs[1] = '{1'b0, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 8'hA1};
        vecs[2] = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 8'hA1};
        vecs[3] = '{1'b1, 8'hAA, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 8'hA1};
        vecs[4] = '{1'b1, 8'hB0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 8'hB0};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 8'hB0};

        rst = 1; s_valid = 0; s_data = 0; frame_abort = 0; frame_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1; rst = 0;
        check_model();

        foreach (vecs[k]) begin
            drive(vecs[k].v, vecs[k].d, vecs[k].ab, vecs[k].fr);
            chk($sformatf("vec%0d_rdy", k), FW'(s_ready), FW'(vecs[k].e_rdy));
            chk($sformatf("vec%0d_fv", k), FW'(frame_valid), FW'(vecs[k].e_fv));
            chk($sformatf("vec%0d_idx", k), FW'(wr_idx), FW'(vecs[k].e_idx));
            chk($sformatf("vec%0d_slot0", k), FW'(frame_data[DW-1:0]), FW'(vecs[k].e_slot0));
        end

        // Asynchronous reset mid-frame, observed before any clock edge.
        for (int i = 0; i < 5; i++) drive(1, 8'h50 + DW'(i), 0, 0);
        rst = 1; #2;
        model_reset();
        chk("rst_async_rdy", FW'(s_ready), FW'(1));
        chk("rst_async_fv", FW'(frame_valid), FW'(0));
        chk("rst_async_idx", FW'(wr_idx), FW'(0));
        chk("rst_async_data", frame_data, FW'(0));
        @(posedge clk); #1; rst = 0;
        check_model();

        // Ordered frame 0x10..0x1F.
        for (int i = 0; i < N; i++) drive(1, 8'h10 + DW'(i), 0, 0);
        chk("frame_fv", FW'(frame_valid), FW'(1));
        chk("frame_rdy", FW'(s_ready), FW'(0));
`ifdef FFT_BITREV_EN
        chk("rev_slot1", FW'(frame_data[1*DW +: DW]), FW'(8'h18));
        chk("rev_slot8", FW'(frame_data[8*DW +: DW]), FW'(8'h11));
        chk("rev_slot3", FW'(frame_data[3*DW +: DW]), FW'(8'h1C));
        chk("rev_slot15", FW'(frame_data[15*DW +: DW]), FW'(8'h1F));
`else
        for (int i = 0; i < N; i++)
            chk($sformatf("nat_slot%0d", i), FW'(frame_data[i*DW +: DW]), FW'(8'h10 + i));
`endif

        // Backpressure: beats offered while held must be ignored.
        saved = frame_data;
        for (int i = 0; i < 10; i++) drive(1, DW'($urandom), ($urandom % 2) == 1, 0);
        chk("bp_data_stable", frame_data, saved);
        drive(0, 0, 0, 1);
        chk("bp_release_rdy", FW'(s_ready), FW'(1));
        for (int i = 0; i < N; i++) drive(1, 8'h60 + DW'(i), 0, 1);
        drive(0, 0, 0, 1);

        // Abort after 7 beats with a concurrent beat of 0xAA.
        for (int i = 0; i < 7; i++) drive(1, 8'h70 + DW'(i), 0, 0);
        drive(1, 8'hAA, 1, 0);
        chk("abort_idx", FW'(wr_idx), FW'(0));
        for (int i = 0; i < N; i++) drive(1, 8'h20 + DW'(i), 0, 0);
        chk("abort_frame_fv", FW'(frame_valid), FW'(1));
        drive(0, 0, 0, 1);

        // Random gaps, backpressure and occasional aborts.
        for (int i = 0; i < 800; i++)
            drive(($urandom % 2) == 1, DW'($urandom), ($urandom % 40) == 0, ($urandom % 3) != 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
